nitta_spi_frame_sequencer: RTL and testbench

NITTA_SPI_FRAME_SEQUENCER -- requirements
Module: nitta_spi_frame_sequencer

---
 rtl/nitta_spi_frame_sequencer.sv | 116 +++++++++++
 tb/tb_nitta_spi_frame_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nitta_spi_frame_sequencer.sv
// Frame buffer between a NITTA word writer and an SPI splitter: collect words,
// commit a frame, then replay it word by word while the SPI master holds chip select.
module nitta_spi_frame_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_SIZE   = 4,
  parameter int PTR_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  commit,
  input  logic                  spi_cs,
  input  logic                  splitter_ready,
  output logic [DATA_WIDTH-1:0] word_out,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overflow,
  output logic [PTR_WIDTH-1:0]  word_cnt,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    READY = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Storage is sized to the pointer range so any rd_ptr value indexes a real entry.
  localparam int MEM_DEPTH = 1 << PTR_WIDTH;
  localparam logic [PTR_WIDTH-1:0] FULL = PTR_WIDTH'(BUF_SIZE);
  localparam logic [PTR_WIDTH-1:0] ONE  = PTR_WIDTH'(1);

  state_t                state, state_next;
  logic [PTR_WIDTH-1:0]  cnt, cnt_next;
  logic [PTR_WIDTH-1:0]  rd_ptr, rd_ptr_next;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic                  store;
  logic                  ovf_set;

  // Splitter handshake: word_out is always valid in SEND; a one-cycle
  // splitter_ready pulse consumes it and the next word appears one cycle later.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    rd_ptr_next = rd_ptr;
    store       = 1'b0;
    ovf_set     = 1'b0;
    case (state)
      FILL: begin
        if (wr) begin
          if (cnt < FULL) store = 1'b1;
          else            ovf_set = 1'b1;
        end
        if (store) cnt_next = cnt + ONE;
        // Commit sees the count including a same-cycle write.
        if (commit && (cnt_next != '0)) state_next = READY;
      end
      READY: begin
        if (spi_cs) begin
          state_next  = SEND;
          rd_ptr_next = '0;
        end
      end
      SEND: begin
        if (!spi_cs) begin
          state_next  = READY;
          rd_ptr_next = '0;
        end else if (splitter_ready) begin
          if (rd_ptr == cnt - ONE) begin
            state_next  = DONE;
            rd_ptr_next = '0;
          end else begin
            rd_ptr_next = rd_ptr + ONE;
          end
        end
      end
      DONE: begin
        state_next  = FILL;
        cnt_next    = '0;
        rd_ptr_next = '0;
      end
      default: begin
        state_next  = FILL;
        cnt_next    = '0;
        rd_ptr_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      cnt        <= '0;
      rd_ptr     <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      rd_ptr     <= rd_ptr_next;
      busy       <= (state_next != FILL);
      frame_done <= (state_next == DONE);
      overflow   <= overflow | ovf_set;
      if (store) mem[cnt] <= data_in;
    end
  end

  assign word_out  = mem[rd_ptr];
  assign word_cnt  = cnt;
  assign state_dbg = state;

endmodule

// File: tb/tb_nitta_spi_frame_sequencer.sv
// Bench for nitta_spi_frame_sequencer: frame-level reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_nitta_spi_frame_sequencer;
  localparam int DW = 32;
  localparam int BS = 4;
  localparam int PW = 3;

  localparam int P_FILL  = 0;
  localparam int P_READY = 1;
  localparam int P_SEND  = 2;
  localparam int P_DONE  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          commit = 1'b0;
  logic          spi_cs = 1'b0;
  logic          splitter_ready = 1'b0;
  logic [DW-1:0] word_out;
  logic          busy;
  logic          frame_done;
  logic          overflow;
  logic [PW-1:0] word_cnt;
  logic [1:0]    state_dbg;

  int checks = 0;
  int errors = 0;
  int done_pulses = 0;

  nitta_spi_frame_sequencer #(
    .DATA_WIDTH(DW),
    .BUF_SIZE  (BS),
    .PTR_WIDTH (PW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr            (wr),
    .data_in       (data_in),
    .commit        (commit),
    .spi_cs        (spi_cs),
    .splitter_ready(splitter_ready),
    .word_out      (word_out),
    .busy          (busy),
    .frame_done    (frame_done),
    .overflow      (overflow),
    .word_cnt      (word_cnt),
    .state_dbg     (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the frame as words held, its lifecycle phase, and the
  // position of the word currently offered to the splitter.
  int            m_phase;
  int            m_cnt;
  int            m_idx;
  logic          m_ovf;
  logic [DW-1:0] m_mem [BS];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = P_FILL;
      m_cnt   = 0;
      m_idx   = 0;
      m_ovf   = 1'b0;
      for (int i = 0; i < BS; i++) m_mem[i] = '0;
    end else begin
      case (m_phase)
        P_FILL: begin
          if (wr) begin
            if (m_cnt < BS) begin
              m_mem[m_cnt] = data_in;
              m_cnt++;
            end else begin
              m_ovf = 1'b1;
            end
          end
          if (commit && m_cnt > 0) m_phase = P_READY;
        end
        P_READY: if (spi_cs) begin
          m_phase = P_SEND;
          m_idx   = 0;
        end
        P_SEND: begin
          if (!spi_cs) begin
            m_phase = P_READY;
            m_idx   = 0;
          end else if (splitter_ready) begin
            if (m_idx == m_cnt - 1) begin
              m_phase = P_DONE;
              m_idx   = 0;
            end else begin
              m_idx++;
            end
          end
        end
        default: begin
          m_phase = P_FILL;
          m_cnt   = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("word_out", word_out, m_mem[m_idx]);
      chk("busy", DW'(busy), DW'(m_phase != P_FILL));
      chk("frame_done", DW'(frame_done), DW'(m_phase == P_DONE));
      chk("overflow", DW'(overflow), DW'(m_ovf));
      chk("word_cnt", DW'(word_cnt), DW'(m_cnt));
      chk("state", DW'(state_dbg), DW'(m_phase));
      if (frame_done) done_pulses++;
    end
  end

  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic c,
                     input logic cs, input logic sr);
    wr = w;
    data_in = d;
    commit = c;
    spi_cs = cs;
    splitter_ready = sr;
    @(negedge clk);
  endtask

  task automatic basic_frame();
    cyc(1'b1, 32'hA0B1C2D3, 1'b0, 1'b0, 1'b0);
    chk("lit_first_wr_cnt", DW'(word_cnt), 32'd1);
    cyc(1'b1, 32'h11223344, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("lit_ready_state", DW'(state_dbg), 32'd1);
    chk("lit_ready_busy", DW'(busy), 32'd1);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("lit_word0", word_out, 32'hA0B1C2D3);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
    chk("lit_word1", word_out, 32'h11223344);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
    chk("lit_frame_done", DW'(frame_done), 32'd1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("lit_after_done_pulse", DW'(frame_done), 32'd0);
    chk("lit_after_done_cnt", DW'(word_cnt), 32'd0);
    chk("lit_after_done_busy", DW'(busy), 32'd0);
  endtask

  initial begin
    int base;
    logic [DW-1:0] ab [3];
    logic [DW-1:0] ov [5];
    ab[0] = 32'h1111_0000; ab[1] = 32'h2222_0000; ab[2] = 32'h3333_0000;
    for (int i = 0; i < 5; i++) ov[i] = 32'h5000_0001 + DW'(i);

    // Asynchronous reset observed before any clock edge.
    #1 rst = 1'b1;
    #2;
    chk("lit_reset_word_out", word_out, 32'h0);
    chk("lit_reset_busy", DW'(busy), 32'd0);
    chk("lit_reset_overflow", DW'(overflow), 32'd0);
    chk("lit_reset_cnt", DW'(word_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    basic_frame();

    // Empty commit and chip select while filling are both no-ops.
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("lit_empty_commit_state", DW'(state_dbg), 32'd0);
    chk("lit_empty_commit_busy", DW'(busy), 32'd0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("lit_cs_in_fill", DW'(state_dbg), 32'd0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Same-cycle write and commit, then a refused write while busy.
    cyc(1'b1, 32'hCAFE0001, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hCAFE0002, 1'b1, 1'b0, 1'b0);
    chk("lit_wr_commit_cnt", DW'(word_cnt), 32'd2);
    chk("lit_wr_commit_state", DW'(state_dbg), 32'd1);
    cyc(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
    chk("lit_busy_wr_cnt", DW'(word_cnt), 32'd2);
    chk("lit_busy_wr_ovf", DW'(overflow), 32'd0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("lit_wc_word0", word_out, 32'hCAFE0001);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
    chk("lit_wc_word1", word_out, 32'hCAFE0002);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Abort mid-frame (abort wins over a same-cycle ready), then a full resend.
    for (int i = 0; i < 3; i++) cyc(1'b1, ab[i], 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    base = done_pulses;
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
    chk("lit_abort_pre_word1", word_out, ab[1]);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("lit_abort_state", DW'(state_dbg), 32'd1);
    chk("lit_abort_word0", word_out, ab[0]);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("lit_resend_word", word_out, ab[i]);
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
    end
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("lit_abort_single_done", DW'(done_pulses - base), 32'd1);

    // Overflow: the fifth word is dropped and the flag sticks.
    for (int i = 0; i < 5; i++) cyc(1'b1, ov[i], 1'b0, 1'b0, 1'b0);
    chk("lit_ovf_flag", DW'(overflow), 32'd1);
    chk("lit_ovf_cnt", DW'(word_cnt), 32'd4);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("lit_ovf_word", word_out, ov[i]);
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
    end
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("lit_ovf_sticky", DW'(overflow), 32'd1);

    // Reset in the middle of a send clears everything without a clock edge.
    cyc(1'b1, 32'h0BAD0001, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h0BAD0002, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
    base = done_pulses;
    #2 rst = 1'b1;
    wr = 1'b0; commit = 1'b0; spi_cs = 1'b0; splitter_ready = 1'b0;
    #1;
    chk("lit_midrst_word_out", word_out, 32'h0);
    chk("lit_midrst_busy", DW'(busy), 32'd0);
    chk("lit_midrst_done", DW'(frame_done), 32'd0);
    chk("lit_midrst_ovf", DW'(overflow), 32'd0);
    chk("lit_midrst_cnt", DW'(word_cnt), 32'd0);
    chk("lit_midrst_state", DW'(state_dbg), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("lit_midrst_no_done", DW'(done_pulses - base), 32'd0);

    basic_frame();
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
